// File: rtl/grid_pixel_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : grid_pixel_fetch
//  Purpose  : Requester side of the sprite-sheet lookup. Turns the VGA scan
//             position into grid cell / sprite-local coordinates, asks the map
//             store for the tile kind, drives kind/x/y to the sprite image
//             block and realigns the returned colour with the scan.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             h_cnt, v_cnt, de      - scan position and display enable
//             map_row, map_col      - cell request to the map store
//             map_kind              - tile kind, one cycle after the request
//             img_kind/img_x/img_y  - sprite lookup request
//             img_clr               - sprite colour, ROM_LAT cycles later
//             rgb, rgb_de           - aligned pixel colour and enable
//  Revision : 1.0 - initial release
// ============================================================================
module grid_pixel_fetch #(
   parameter int          GX0     = 8,
   parameter int          GY0     = 30,
   parameter int          CELL_W  = 48,
   parameter int          CELL_H  = 70,
   parameter int          COLS    = 13,
   parameter int          ROWS    = 6,
   parameter int          ROM_LAT = 1,
   parameter logic [11:0] BG_CLR  = 12'h000,
   parameter logic [11:0] KEY_CLR = 12'hF0F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  h_cnt,
   input  logic [9:0]  v_cnt,
   input  logic        de,
   output logic [2:0]  map_row,
   output logic [3:0]  map_col,
   input  logic [4:0]  map_kind,
   output logic [4:0]  img_kind,
   output logic [5:0]  img_x,
   output logic [6:0]  img_y,
   input  logic [11:0] img_clr,
   output logic [11:0] rgb,
   output logic        rgb_de
);

   localparam logic [9:0] c_h_lo    = 10'(GX0);
   localparam logic [9:0] c_h_hi    = 10'(GX0 + COLS * CELL_W);
   localparam logic [9:0] c_v_lo    = 10'(GY0);
   localparam logic [9:0] c_v_hi    = 10'(GY0 + ROWS * CELL_H);
   localparam logic [5:0] c_sx_last = 6'(CELL_W - 1);
   localparam logic [6:0] c_sy_last = 7'(CELL_H - 1);

   // S1: scan position converted to cell coordinates
   logic       in_grid_q, in_grid_d;
   logic [5:0] sx_q, sx_d;
   logic [3:0] col_q, col_d;
   logic [6:0] sy_q, sy_d;
   logic [2:0] row_q, row_d;
   logic       de1_q;
   logic       w_line_start;

   // S2: aligned with map_kind coming back from the map store
   logic       g2_q;
   logic [5:0] sx2_q;
   logic [6:0] sy2_q;
   logic       de2_q;

   // Delay line matching the image lookup latency
   logic [ROM_LAT-1:0] g_dly_q;
   logic [ROM_LAT-1:0] de_dly_q;

   // Output register
   logic [11:0] rgb_q, rgb_d;
   logic        rgb_de_q;

   // The first grid column restarts the horizontal count and is also the one
   // cycle per line on which the vertical count advances.
   assign w_line_start = (h_cnt == c_h_lo);

   always_comb begin
      in_grid_d = de &&
                  (h_cnt >= c_h_lo) && (h_cnt < c_h_hi) &&
                  (v_cnt >= c_v_lo) && (v_cnt < c_v_hi);
      sx_d  = sx_q;
      col_d = col_q;
      sy_d  = sy_q;
      row_d = row_q;

      // Outside the grid the counters run on freely; the in-grid flag masks
      // whatever they produce there, including col overflow past COLS-1.
      if (w_line_start) begin
         sx_d  = '0;
         col_d = '0;
      end else if (sx_q == c_sx_last) begin
         sx_d  = '0;
         col_d = col_q + 4'd1;
      end else begin
         sx_d  = sx_q + 6'd1;
      end

      if (w_line_start) begin
         if (v_cnt == c_v_lo) begin
            sy_d  = '0;
            row_d = '0;
         end else if (sy_q == c_sy_last) begin
            sy_d  = '0;
            row_d = row_q + 3'd1;
         end else begin
            sy_d  = sy_q + 7'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_grid_q <= 1'b0;
         sx_q      <= '0;
         col_q     <= '0;
         sy_q      <= '0;
         row_q     <= '0;
         de1_q     <= 1'b0;
      end else begin
         in_grid_q <= in_grid_d;
         sx_q      <= sx_d;
         col_q     <= col_d;
         sy_q      <= sy_d;
         row_q     <= row_d;
         de1_q     <= de;
      end
   end

   assign map_row = row_q;
   assign map_col = col_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         g2_q  <= 1'b0;
         sx2_q <= '0;
         sy2_q <= '0;
         de2_q <= 1'b0;
      end else begin
         g2_q  <= in_grid_q;
         sx2_q <= sx_q;
         sy2_q <= sy_q;
         de2_q <= de1_q;
      end
   end

   // map_kind already arrives in step with S2, so it is forwarded unregistered.
   assign img_kind = map_kind;
   assign img_x    = sx2_q;
   assign img_y    = sy2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         g_dly_q  <= '0;
         de_dly_q <= '0;
      end else begin
         g_dly_q[0]  <= g2_q;
         de_dly_q[0] <= de2_q;
         for (int i = 1; i < ROM_LAT; i++) begin
            g_dly_q[i]  <= g_dly_q[i-1];
            de_dly_q[i] <= de_dly_q[i-1];
         end
      end
   end

   // Colour-keyed sprite pixels show the background through.
   always_comb begin
      rgb_d = img_clr;
      if (!g_dly_q[ROM_LAT-1] || (img_clr == KEY_CLR)) begin
         rgb_d = BG_CLR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_q    <= 12'h000;
         rgb_de_q <= 1'b0;
      end else begin
         rgb_q    <= rgb_d;
         rgb_de_q <= de_dly_q[ROM_LAT-1];
      end
   end

   assign rgb    = rgb_q;
   assign rgb_de = rgb_de_q;

endmodule
`default_nettype wire
